// File: rtl/fetch_stage_auto.sv
// Instruction-fetch stage: PC/MAR/MDR/IR sequenced by an external 2-bit phase code.
// Optional macro FETCH_VALID_EN adds the fetch_valid output (one-cycle pulse after each IR load).
module fetch_stage_auto #(
  parameter int DATA_W = 68,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ControlSig_1,
  input  logic              ControlSig_2,
  input  logic              PC_write,
  input  logic [ADDR_W-1:0] PC_addressin,
  input  logic              PM_wr,
  input  logic [DATA_W-1:0] PM_inst_inp,
  input  logic [DATA_W-1:0] pm_rdata,
  output logic [ADDR_W-1:0] pm_addr,
  output logic              pm_read,
  output logic              pm_we,
  output logic [DATA_W-1:0] pm_wdata,
  output logic [DATA_W-1:0] Fetch_out
`ifdef FETCH_VALID_EN
  ,
  output logic              fetch_valid
`endif
);

  typedef enum logic [1:0] {
    SIG1 = 2'b00,
    SIG2 = 2'b01,
    SIG3 = 2'b10,
    SIG4 = 2'b11
  } phase_e;

  phase_e            phase;
  logic [3:0]        phase_oh;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] mar_q, mar_d;
  logic [DATA_W-1:0] mdr_q, mdr_d;
  logic [DATA_W-1:0] ir_q, ir_d;

  // One-hot phase decode from the external control bits.
  always_comb begin
    phase    = phase_e'({ControlSig_2, ControlSig_1});
    phase_oh = 4'b0000;
    case (phase)
      SIG1:    phase_oh = 4'b0001;
      SIG2:    phase_oh = 4'b0010;
      SIG3:    phase_oh = 4'b0100;
      SIG4:    phase_oh = 4'b1000;
      default: phase_oh = 4'b0000;
    endcase
  end

  // Next-state for the fetch registers; a loader write freezes MDR/IR and the PC increment.
  always_comb begin
    pc_d  = pc_q;
    mar_d = mar_q;
    mdr_d = mdr_q;
    ir_d  = ir_q;
    if (phase_oh[0]) begin
      mar_d = pc_q;
    end else begin
      mar_d = mar_q;
    end
    if (!PM_wr && phase_oh[2]) begin
      mdr_d = pm_rdata;
    end else begin
      mdr_d = mdr_q;
    end
    if (!PM_wr && phase_oh[3]) begin
      ir_d = mdr_q;
      pc_d = pc_q + ADDR_W'(1);
    end else begin
      ir_d = ir_q;
      pc_d = pc_q;
    end
    // An explicit PC load wins over the sequential increment.
    if (PC_write) begin
      pc_d = PC_addressin;
    end else begin
      pc_d = pc_d;
    end
  end

  // Fetch register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
      ir_q  <= '0;
    end else begin
      pc_q  <= pc_d;
      mar_q <= mar_d;
      mdr_q <= mdr_d;
      ir_q  <= ir_d;
    end
  end

`ifdef FETCH_VALID_EN
  logic fetch_valid_q;

  // Pulse marks the cycle after a real IR load.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_valid_q <= 1'b0;
    end else begin
      fetch_valid_q <= phase_oh[3] & ~PM_wr;
    end
  end

  assign fetch_valid = fetch_valid_q;
`endif

  assign pm_addr   = mar_q;
  assign pm_read   = phase_oh[1] & ~PM_wr & ~reset;
  assign pm_we     = PM_wr & ~reset;
  assign pm_wdata  = PM_wr ? PM_inst_inp : '0;
  assign Fetch_out = ir_q;

endmodule

// File: tb/tb_fetch_stage_auto.sv
// Self-checking bench for fetch_stage_auto: behavioural program memory, reference model, scoreboard.
module tb_fetch_stage_auto;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ControlSig_1 = 1'b0;
  logic        ControlSig_2 = 1'b0;
  logic        PC_write = 1'b0;
  logic [4:0]  PC_addressin = 5'd0;
  logic        PM_wr = 1'b0;
  logic [67:0] PM_inst_inp = 68'd0;
  logic [67:0] pm_rdata = 68'd0;
  logic [4:0]  pm_addr;
  logic        pm_read;
  logic        pm_we;
  logic [67:0] pm_wdata;
  logic [67:0] Fetch_out;
`ifdef FETCH_VALID_EN
  logic        fetch_valid;
`endif

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [67:0] mem  [32];
  logic [67:0] gold [32];
  logic [67:0] prog [4];
  logic [67:0] sb_q [$];

  logic [4:0]  exp_pc, exp_mar;
  logic [67:0] exp_mdr, exp_ir, exp_rd;
  logic        exp_fv;
  logic [4:0]  last_read_addr;

  always #5 clk = ~clk;

  fetch_stage_auto #(.DATA_W(68), .ADDR_W(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .ControlSig_1 (ControlSig_1),
    .ControlSig_2 (ControlSig_2),
    .PC_write     (PC_write),
    .PC_addressin (PC_addressin),
    .PM_wr        (PM_wr),
    .PM_inst_inp  (PM_inst_inp),
    .pm_rdata     (pm_rdata),
    .pm_addr      (pm_addr),
    .pm_read      (pm_read),
    .pm_we        (pm_we),
    .pm_wdata     (pm_wdata),
    .Fetch_out    (Fetch_out)
`ifdef FETCH_VALID_EN
    ,
    .fetch_valid  (fetch_valid)
`endif
  );

  // Synchronous program memory: write and one-cycle-latency read.
  always @(posedge clk) begin
    if (pm_we) mem[pm_addr] <= pm_wdata;
    if (pm_read) pm_rdata <= mem[pm_addr];
  end

  // One clock of stimulus: combinational checks mid-cycle, model + scoreboard after the edge.
  task automatic step(input logic [1:0] ph, input logic rst, input logic pcw,
                      input logic [4:0] pca, input logic wr, input logic [67:0] wd,
                      input string tag);
    logic        e_read, e_we;
    logic [67:0] e_wdata, old_rd, old_mdr, got;
    logic [4:0]  old_pc;
    bit          popped;
    {ControlSig_2, ControlSig_1} = ph;
    reset = rst; PC_write = pcw; PC_addressin = pca; PM_wr = wr; PM_inst_inp = wd;
    e_read  = (ph == 2'b01) && !wr && !rst;
    e_we    = wr && !rst;
    e_wdata = wr ? wd : 68'd0;
    if (ph == 2'b11 && !wr && !rst) sb_q.push_back(exp_mdr);
    @(negedge clk);
    if (pm_read) last_read_addr = pm_addr;
    total_cnt++;
    if (pm_read !== e_read) $display("FAIL %s pm_read: got %0b want %0b", tag, pm_read, e_read);
    else pass_cnt++;
    total_cnt++;
    if (pm_we !== e_we) $display("FAIL %s pm_we: got %0b want %0b", tag, pm_we, e_we);
    else pass_cnt++;
    total_cnt++;
    if (pm_addr !== exp_mar) $display("FAIL %s pm_addr: got %h want %h", tag, pm_addr, exp_mar);
    else pass_cnt++;
    total_cnt++;
    if (pm_wdata !== e_wdata) $display("FAIL %s pm_wdata: got %h want %h", tag, pm_wdata, e_wdata);
    else pass_cnt++;
    @(posedge clk);
    old_rd = exp_rd; old_mdr = exp_mdr; old_pc = exp_pc;
    if (rst) begin
      exp_pc = 5'd0; exp_mar = 5'd0; exp_mdr = 68'd0; exp_ir = 68'd0; exp_fv = 1'b0;
      sb_q.delete();
    end else begin
      if (wr) gold[exp_mar] = wd;
      if (e_read) exp_rd = gold[exp_mar];
      if (ph == 2'b00) exp_mar = old_pc;
      if (!wr && ph == 2'b10) exp_mdr = old_rd;
      if (!wr && ph == 2'b11) begin
        exp_ir = old_mdr;
        exp_pc = old_pc + 5'd1;
      end
      if (pcw) exp_pc = pca;
      exp_fv = (ph == 2'b11) && !wr;
    end
    #1;
    popped = 1'b0;
    if (sb_q.size() > 0) begin
      got = sb_q.pop_front();
      popped = 1'b1;
    end
    total_cnt++;
    if (popped) begin
      if (Fetch_out !== got) $display("FAIL %s fetch_out_sb: got %h want %h", tag, Fetch_out, got);
      else pass_cnt++;
    end else begin
      if (Fetch_out !== exp_ir) $display("FAIL %s fetch_out_hold: got %h want %h", tag, Fetch_out, exp_ir);
      else pass_cnt++;
    end
`ifdef FETCH_VALID_EN
    total_cnt++;
    if (fetch_valid !== exp_fv) $display("FAIL %s fetch_valid: got %0b want %0b", tag, fetch_valid, exp_fv);
    else pass_cnt++;
`endif
  endtask

  task automatic fetch(input string tag);
    step(2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, tag);
    step(2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, tag);
    step(2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, tag);
    step(2'b11, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, tag);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(2'b01, 1'b1, 1'b0, 5'd0, 1'b0, 68'd0, "reset");
    total_cnt++;
    if (Fetch_out !== 68'd0 || pm_addr !== 5'd0)
      $display("FAIL reset_state: got fetch=%h addr=%h want 0/0", Fetch_out, pm_addr);
    else pass_cnt++;
  endtask

  task automatic test_single_fetch();
    last_read_addr = 5'h1A;
    fetch("single");
    total_cnt++;
    if (Fetch_out !== 68'h9_00000000_00000003 || last_read_addr !== 5'd0)
      $display("FAIL single_fetch: got fetch=%h addr=%h want 900000000000000003/00",
               Fetch_out, last_read_addr);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    step(2'b00, 1'b1, 1'b0, 5'd0, 1'b0, 68'd0, "b2b_rst");
    for (int i = 0; i < 4; i++) begin
      fetch("b2b");
      total_cnt++;
      if (Fetch_out !== prog[i] || last_read_addr !== 5'(i))
        $display("FAIL b2b_%0d: got fetch=%h addr=%h want %h/%h", i, Fetch_out,
                 last_read_addr, prog[i], 5'(i));
      else pass_cnt++;
    end
  endtask

  task automatic test_pc_write_wrap();
    step(2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "pcw");
    step(2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "pcw");
    step(2'b10, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "pcw");
    step(2'b11, 1'b0, 1'b1, 5'h1F, 1'b0, 68'd0, "pcw");
    total_cnt++;
    if (last_read_addr !== 5'd4) $display("FAIL pc_after_b2b: got %h want 04", last_read_addr);
    else pass_cnt++;
    fetch("pcw_1f");
    total_cnt++;
    if (last_read_addr !== 5'h1F || Fetch_out !== 68'h7_00000000_0000001F)
      $display("FAIL pcw_jump: got addr=%h fetch=%h want 1f/70000000000000001f", last_read_addr, Fetch_out);
    else pass_cnt++;
  endtask

  task automatic test_pm_write();
    logic [67:0] held;
    held = Fetch_out;
    for (int p = 0; p < 4; p++)
      step(2'(p), 1'b0, 1'b0, 5'd0, 1'b1, 68'hA_00000000_00000005, "pmwr");
    total_cnt++;
    if (Fetch_out !== held) $display("FAIL pmwr_frozen: got %h want %h", Fetch_out, held);
    else pass_cnt++;
    fetch("pmwr_rd");
    total_cnt++;
    if (last_read_addr !== 5'd0 || Fetch_out !== 68'hA_00000000_00000005)
      $display("FAIL pmwr_readback: got addr=%h fetch=%h want 00/a00000000000000005", last_read_addr, Fetch_out);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_fetch();
    step(2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "midrst");
    step(2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "midrst");
    step(2'b10, 1'b1, 1'b0, 5'd0, 1'b0, 68'd0, "midrst");
    total_cnt++;
    if (Fetch_out !== 68'd0 || pm_addr !== 5'd0)
      $display("FAIL midrst_clear: got fetch=%h addr=%h want 0/0", Fetch_out, pm_addr);
    else pass_cnt++;
    last_read_addr = 5'h15;
    step(2'b00, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "midrst_s1");
    step(2'b01, 1'b0, 1'b0, 5'd0, 1'b0, 68'd0, "midrst_s2");
    total_cnt++;
    if (last_read_addr !== 5'd0) $display("FAIL midrst_mar: got %h want 00", last_read_addr);
    else pass_cnt++;
  endtask

  initial begin
    prog[0] = 68'h9_00000000_00000003;
    prog[1] = 68'h4_00000001_00000004;
    prog[2] = 68'h6_00000000_00000001;
    prog[3] = 68'hB_00000000_00000005;
    for (int a = 0; a < 32; a++) begin
      mem[a]  = {36'h3_0000_0000, 27'd0, 5'(a)};
      gold[a] = {36'h3_0000_0000, 27'd0, 5'(a)};
    end
    for (int a = 0; a < 4; a++) begin
      mem[a]  = prog[a];
      gold[a] = prog[a];
    end
    mem[31]  = 68'h7_00000000_0000001F;
    gold[31] = 68'h7_00000000_0000001F;
    exp_pc = 5'd0; exp_mar = 5'd0; exp_mdr = 68'd0; exp_ir = 68'd0;
    exp_rd = 68'd0; exp_fv = 1'b0; last_read_addr = 5'd0;

    test_reset();
    test_single_fetch();
    test_back_to_back();
    test_pc_write_wrap();
    test_pm_write();
    test_reset_mid_fetch();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/fetch_stage_auto.md
Name: fetch_stage_auto

Overview:
- Instruction-fetch stage of the 68-bit pipelined processor.
- Contains the program counter (PC), memory address register (MAR), memory data register (MDR), instruction register (IR) and a small fetch control unit.
- An external 2-bit phase code {ControlSig_2, ControlSig_1} sequences one fetch over four clock cycles: PC->MAR, program-memory read, PM->MDR, MDR->IR with PC increment.
- Drives a synchronous program memory and presents the fetched instruction on Fetch_out to decode.

Parameters:
- DATA_W, 68, instruction/data width (opcode[67:65], mode[64], operand A[63:32], operand B[31:0]).
- ADDR_W, 5, program-memory address width (32 words).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  synchronous, active-high reset.
- ControlSig_1  in  1  phase code bit 0.
- ControlSig_2  in  1  phase code bit 1.
- PC_write  in  1  load PC from PC_addressin.
- PC_addressin  in  ADDR_W  PC load value (jump/start address).
- PM_wr  in  1  program-memory write request (loader).
- PM_inst_inp  in  DATA_W  word to write into program memory.
- pm_rdata  in  DATA_W  read data from program memory (valid one cycle after pm_read).
- pm_addr  out  ADDR_W  program-memory address, equals MAR.
- pm_read  out  1  program-memory read enable.
- pm_we  out  1  program-memory write enable.
- pm_wdata  out  DATA_W  program-memory write data.
- Fetch_out  out  DATA_W  current instruction (IR contents).

Behaviour:
- Phase decode, combinational and one-hot: phase = {ControlSig_2, ControlSig_1}. 00 = sig1, 01 = sig2, 10 = sig3, 11 = sig4. Each phase is held one clock cycle; a full fetch takes 4 cycles.
- Reset (sampled on posedge, priority over everything): PC, MAR, MDR, IR = 0; Fetch_out = 0; pm_read = 0; pm_we = 0.
- sig1: MAR <= PC.
- sig2: pm_read = 1 (combinational during the phase), pm_addr = MAR. The memory samples on this edge.
- sig3: MDR <= pm_rdata.
- sig4: IR <= MDR; PC <= PC + 1, modulo 2^ADDR_W (31 wraps to 0).
- Fetch_out is IR, registered. It changes only on a sig4 edge and holds otherwise.
- PC_write = 1: PC <= PC_addressin on that edge, in any phase. It takes priority over the sig4 increment. The new PC is used at the next sig1.
- PM_wr = 1:
  - pm_we = 1 and pm_wdata = PM_inst_inp; pm_addr = MAR.
  - pm_read forced to 0.
  - MDR/IR/PC updates suppressed (fetch frozen).
  - The phase code continues externally; fetch resumes in whatever phase is present when PM_wr falls.
- PM_wr = 0: pm_we = 0 and pm_wdata = 0.
- Phases that skip or repeat are honoured literally; no internal sequencing state beyond the registers.
- Reset mid-fetch aborts the fetch. The next sig1 after reset loads MAR with 0.

Optional Feature:
- Macro FETCH_VALID_EN.
- Defined: adds output fetch_valid (1 bit). It is high for exactly the cycle after each sig4 edge that loaded IR (not when frozen by PM_wr). It is 0 in reset.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset then run phases 00,01,10,11 with PM[0] = 0x9_00000000_00000003 -> Fetch_out = 0x9_00000000_00000003 after the sig4 edge; PC = 1; pm_read high only in the 01 cycle with pm_addr = 0.
- Four consecutive fetches from PM[0..3] (LDA 0x03, MOV B 0x04, ADD B, STA 0x05) -> Fetch_out sequence matches PM[0..3]; pm_addr 0,1,2,3; final PC = 4.
- PC_write = 1, PC_addressin = 5'h1F during phase 11 -> PC = 0x1F (no increment). The next fetch reads address 0x1F, then PC wraps to 0.
- PM_wr = 1 with PM_inst_inp = 0xA_00000000_00000005 across a full phase cycle -> pm_we = 1, pm_read = 0, Fetch_out and PC unchanged.
- Assert reset during phase 10 -> next edge: PC/MAR/MDR/IR/Fetch_out = 0. The following sig1 loads MAR = 0.
- With FETCH_VALID_EN: fetch_valid is a single-cycle pulse after each sig4 and stays 0 when PM_wr is high.
